// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // A divisor of zero would never produce a bit boundary, so clamp it to one.
  function automatic logic [31:0] prescale_floor(input logic [31:0] p);
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..prescale-1 while enabled and strobes bit_end_o on the last clock.
module uart_baud_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] prescale_i,
  output logic             bit_end_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // prescale_i is never zero here, so the subtraction cannot wrap.
  assign bit_end_o = en_i && (cnt_q == (prescale_i - WIDTH'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = bit_end_o ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Run-time configurable UART transmitter: latches data and frame format on accept,
// then shifts start, data (LSB first), optional parity and 1 or 2 stop bits.
module uart_tx_cfg
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  output logic                      TX_OUT,
  output logic                      BUSY,
  output logic                      TX_DONE
);

  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

  tx_state_e                 state_q;
  logic [DATA_WIDTH-1:0]     shreg_q;
  logic [IDX_W-1:0]          idx_q;
  logic                      parity_q;
  logic                      par_en_q;
  logic                      stop2_q;
  logic                      stop_half_q;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic                      tx_q;
  logic                      busy_q;
  logic                      done_q;

  logic accept;
  logic bit_end;

  assign accept = (state_q == ST_IDLE) && DATA_VALID;

  uart_baud_cnt #(
    .WIDTH(PRESCALE_WIDTH)
  ) u_baud_cnt (
    .clk_i     (CLK),
    .rst_ni    (RST),
    .load_i    (accept),
    .en_i      (state_q != ST_IDLE),
    .prescale_i(prescale_q),
    .bit_end_o (bit_end)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      idx_q       <= '0;
      parity_q    <= 1'b0;
      par_en_q    <= 1'b0;
      stop2_q     <= 1'b0;
      stop_half_q <= 1'b0;
      prescale_q  <= PRESCALE_WIDTH'(1);
      tx_q        <= STOP_BIT;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (DATA_VALID) begin
            state_q     <= ST_START;
            shreg_q     <= P_DATA;
            idx_q       <= '0;
            parity_q    <= (^P_DATA) ^ PAR_TYP;
            par_en_q    <= PAR_EN;
            stop2_q     <= STOP2;
            stop_half_q <= 1'b0;
            prescale_q  <= PRESCALE_WIDTH'(prescale_floor(32'(PRESCALE)));
            tx_q        <= START_BIT;
            busy_q      <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state_q <= ST_DATA;
            tx_q    <= shreg_q[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
              state_q <= par_en_q ? ST_PARITY : ST_STOP;
              tx_q    <= par_en_q ? parity_q : STOP_BIT;
            end else begin
              // Look one bit ahead so the next data bit is registered on the boundary.
              idx_q   <= idx_q + IDX_W'(1);
              shreg_q <= shreg_q >> 1;
              tx_q    <= shreg_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state_q <= ST_STOP;
            tx_q    <= STOP_BIT;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (stop2_q && !stop_half_q) begin
              stop_half_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              tx_q    <= STOP_BIT;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= STOP_BIT;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT  = tx_q;
  assign BUSY    = busy_q;
  assign TX_DONE = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: expected frames are queued at drive time and
// checked clock-by-clock on the falling edge against an 8-bit and a 9-bit instance.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] prescale;
  logic        par_en, par_typ, stop2;
  logic [7:0]  pdata8;
  logic [8:0]  pdata9;
  logic        dv8, dv9;
  logic        tx8, busy8, done8;
  logic        tx9, busy9, done9;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic       sel;
    logic [8:0] data;
    logic       pe;
    logic       pt;
    logic       s2;
    int         p;
  } frame_t;

  frame_t exp_q[$];

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_WIDTH(8), .PRESCALE_WIDTH(16)) dut8 (
    .CLK(clk), .RST(rst_n), .PRESCALE(prescale), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .STOP2(stop2), .P_DATA(pdata8), .DATA_VALID(dv8),
    .TX_OUT(tx8), .BUSY(busy8), .TX_DONE(done8)
  );

  uart_tx_cfg #(.DATA_WIDTH(9), .PRESCALE_WIDTH(16)) dut9 (
    .CLK(clk), .RST(rst_n), .PRESCALE(prescale), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .STOP2(stop2), .P_DATA(pdata9), .DATA_VALID(dv9),
    .TX_OUT(tx9), .BUSY(busy9), .TX_DONE(done9)
  );

  function automatic logic tx_of(input logic sel);
    return sel ? tx9 : tx8;
  endfunction

  function automatic logic busy_of(input logic sel);
    return sel ? busy9 : busy8;
  endfunction

  function automatic logic done_of(input logic sel);
    return sel ? done9 : done8;
  endfunction

  task automatic push_exp(input logic sel, input logic [8:0] data, input logic pe,
                          input logic pt, input logic s2, input logic [15:0] p);
    frame_t f;
    f.sel  = sel;
    f.data = sel ? data : {1'b0, data[7:0]};
    f.pe   = pe;
    f.pt   = pt;
    f.s2   = s2;
    f.p    = (p == 16'd0) ? 1 : int'(p);
    exp_q.push_back(f);
  endtask

  // Presents a frame for one cycle (or leaves DATA_VALID high when hold is set).
  // Returns 1 time unit after the accepting edge.
  task automatic drive_frame(input logic sel, input logic [8:0] data, input logic pe,
                             input logic pt, input logic s2, input logic [15:0] p,
                             input bit hold);
    @(posedge clk);
    #1;
    prescale = p;
    par_en   = pe;
    par_typ  = pt;
    stop2    = s2;
    if (sel) begin
      pdata9 = data;
      dv9    = 1'b1;
    end else begin
      pdata8 = data[7:0];
      dv8    = 1'b1;
    end
    push_exp(sel, data, pe, pt, s2, p);
    @(posedge clk);
    #1;
    if (!hold) begin
      dv8 = 1'b0;
      dv9 = 1'b0;
    end
  endtask

  // Pops one expected frame and checks every clock of it plus the TX_DONE cycle.
  // Ends on the falling edge of the TX_DONE cycle.
  task automatic check_frame(output int waited);
    frame_t f;
    logic   bits[$];
    logic   par;
    int     dw;
    waited = 0;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL scoreboard_empty: no expected frame queued");
      return;
    end
    f  = exp_q.pop_front();
    dw = f.sel ? 9 : 8;
    bits.push_back(1'b0);
    par = f.pt;
    for (int i = 0; i < dw; i++) begin
      bits.push_back(f.data[i]);
      par = par ^ f.data[i];
    end
    if (f.pe) bits.push_back(par);
    bits.push_back(1'b1);
    if (f.s2) bits.push_back(1'b1);

    @(negedge clk);
    while (busy_of(f.sel) !== 1'b1 && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    if (busy_of(f.sel) !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_rise: BUSY=%b after %0d clocks, required 1", busy_of(f.sel), waited);
      return;
    end
    $display("[TB] frame dw=%0d data=0x%0h pe=%0b pt=%0b s2=%0b p=%0d bits=%0d",
             dw, f.data, f.pe, f.pt, f.s2, f.p, bits.size());
    for (int k = 0; k < bits.size(); k++) begin
      for (int c = 0; c < f.p; c++) begin
        tests_run++;
        if (tx_of(f.sel) !== bits[k] || busy_of(f.sel) !== 1'b1 || done_of(f.sel) !== 1'b0) begin
          tests_failed++;
          $display("FAIL frame_bit[%0d] clk %0d: TX_OUT=%b BUSY=%b TX_DONE=%b, required %b/1/0",
                   k, c, tx_of(f.sel), busy_of(f.sel), done_of(f.sel), bits[k]);
        end
        @(negedge clk);
      end
    end
    tests_run++;
    if (busy_of(f.sel) !== 1'b0 || done_of(f.sel) !== 1'b1 || tx_of(f.sel) !== 1'b1) begin
      tests_failed++;
      $display("FAIL frame_end: BUSY=%b TX_DONE=%b TX_OUT=%b, required 0/1/1",
               busy_of(f.sel), done_of(f.sel), tx_of(f.sel));
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    prescale = '0;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    stop2    = 1'b0;
    pdata8   = '0;
    pdata9   = '0;
    dv8      = 1'b0;
    dv9      = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({tx8, busy8, done8, tx9, busy9, done9} !== 6'b100_100) begin
      tests_failed++;
      $display("FAIL reset_state: tx/busy/done = %b%b%b %b%b%b, required 100 100",
               tx8, busy8, done8, tx9, busy9, done9);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_parity_frame();
    int w;
    drive_frame(1'b0, 9'h0A5, 1'b1, 1'b0, 1'b0, 16'd4, 1'b0);
    check_frame(w);
    tests_run++;
    if (w !== 0) begin
      tests_failed++;
      $display("FAIL accept_latency: BUSY rose after %0d extra clocks, required 0", w);
    end
    @(negedge clk);
    tests_run++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_single: TX_DONE=%b BUSY=%b, required 0/0", done8, busy8);
    end
  endtask

  task automatic test_odd_stop2();
    int w;
    drive_frame(1'b0, 9'h000, 1'b1, 1'b1, 1'b1, 16'd2, 1'b0);
    check_frame(w);
  endtask

  task automatic test_back_to_back();
    int w1, w2;
    drive_frame(1'b0, 9'h0FF, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
    push_exp(1'b0, 9'h0FF, 1'b0, 1'b0, 1'b0, 16'd0);
    check_frame(w1);
    fork
      check_frame(w2);
      begin
        @(posedge clk);
        #1;
        dv8 = 1'b0;
      end
    join
    tests_run++;
    if (w2 !== 0) begin
      tests_failed++;
      $display("FAIL b2b_gap: second START after %0d extra idle clocks, required 0", w2);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (busy8 !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_no_third: BUSY=%b at idle clock %0d, required 0", busy8, i);
      end
    end
  endtask

  task automatic test_midframe_change();
    int w;
    drive_frame(1'b0, 9'h03C, 1'b1, 1'b1, 1'b0, 16'd3, 1'b0);
    fork
      check_frame(w);
      begin
        repeat (4) @(posedge clk);
        #1;
        pdata8   = 8'hC3;
        prescale = 16'd7;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        stop2    = 1'b1;
        dv8      = 1'b1;
        @(posedge clk);
        #1;
        dv8 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        dv8 = 1'b1;
        @(posedge clk);
        #1;
        dv8 = 1'b0;
      end
    join
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      tests_run++;
      if (busy8 !== 1'b0 || tx8 !== 1'b1) begin
        tests_failed++;
        $display("FAIL dropped_valid: BUSY=%b TX_OUT=%b at idle clock %0d, required 0/1",
                 busy8, tx8, i);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int w;
    drive_frame(1'b0, 9'h05A, 1'b0, 1'b0, 1'b0, 16'd4, 1'b0);
    exp_q.delete();
    // Clock 13 of the frame sits in data bit 2 of 0x5A, which is a 0 on the line.
    repeat (13) @(posedge clk);
    #2;
    tests_run++;
    if (tx8 !== 1'b0 || busy8 !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset: TX_OUT=%b BUSY=%b, required 0/1", tx8, busy8);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (tx8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: TX_OUT=%b BUSY=%b TX_DONE=%b, required 1/0/0",
               tx8, busy8, done8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests_run++;
      if (tx8 !== 1'b1 || busy8 !== 1'b0) begin
        tests_failed++;
        $display("FAIL post_reset_idle: TX_OUT=%b BUSY=%b at clock %0d, required 1/0",
                 tx8, busy8, i);
      end
    end
    drive_frame(1'b0, 9'h081, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0);
    check_frame(w);
  endtask

  task automatic test_9bit();
    int w;
    drive_frame(1'b1, 9'h1FF, 1'b1, 1'b0, 1'b0, 16'd2, 1'b0);
    check_frame(w);
    drive_frame(1'b1, 9'h10A, 1'b1, 1'b1, 1'b1, 16'd1, 1'b0);
    check_frame(w);
  endtask

  initial begin
    test_reset();
    test_parity_frame();
    test_odd_stop2();
    test_back_to_back();
    test_midframe_change();
    test_reset_midframe();
    test_9bit();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
- Parametrised, run-time-configurable UART transmitter; successor to the fixed-rate 8-bit TX top.
- Adds an internal baud prescaler, 1 or 2 stop bits and a configurable data width.
- Latches frame configuration and data on acceptance, so inputs may change mid-frame.
- Drives the serial line directly and sits between the register interface and the pad.

Parameters:
- DATA_WIDTH, 8, payload bits per frame (5..9 supported).
- PRESCALE_WIDTH, 16, width of the clocks-per-bit divisor input.

Ports:
- CLK  input  1  system clock.
- RST  input  1  reset, asynchronous, active-low.
- PRESCALE  input  PRESCALE_WIDTH  clocks per bit; a value of 0 is treated as 1.
- PAR_EN  input  1  1 = append a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- STOP2  input  1  1 = two stop bits, 0 = one.
- P_DATA  input  DATA_WIDTH  parallel payload.
- DATA_VALID  input  1  request to send P_DATA.
- TX_OUT  output  1  serial line, idle high.
- BUSY  output  1  high while a frame is in progress.
- TX_DONE  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset (RST=0, async): TX_OUT=1, BUSY=0, TX_DONE=0, state IDLE, all counters 0. Reset mid-frame aborts immediately; the line returns high with no glitch low.
- Accept: on a rising CLK edge with state IDLE and DATA_VALID=1.
  - Latch P_DATA, PAR_EN, PAR_TYP, STOP2 and max(PRESCALE,1).
  - DATA_VALID is ignored while BUSY=1; there is no queueing.
- Latency: from the accept edge, TX_OUT=0 and BUSY=1 are registered outputs valid the next cycle.
- Timing: each bit is held exactly P clocks, where P is the latched prescale.
- Bit counter: a bit counter counts 0..P-1. Advance to the next bit when the counter reaches P-1, then reset the counter to 0.
- FSM states and transitions:
  - IDLE -> START on accept.
  - START -> DATA after P clocks.
  - DATA sends DATA_WIDTH bits, LSB first, using an index 0..DATA_WIDTH-1.
  - DATA -> PARITY if PAR_EN, else DATA -> STOP.
  - PARITY -> STOP.
  - STOP holds 1 for P clocks, or 2P clocks when STOP2 is set.
  - STOP -> IDLE.
- TX_OUT values by state: 1 in IDLE, 0 in START, the data bit in DATA, the parity bit in PARITY, 1 in STOP. All values are registered; there is no combinational path from inputs to TX_OUT.
- Parity: computed on the latched data. Parity bit = XOR of data bits for even, inverted XOR for odd.
- Frame end:
  - BUSY falls and TX_DONE pulses high for one cycle on the edge leaving STOP.
  - DATA_VALID high in that same IDLE cycle is accepted on the next edge, so back-to-back frames have a 1-clock idle gap.
- Frame length (clocks): P*(1 + DATA_WIDTH + PAR_EN + 1 + STOP2) + 1 idle clock before the next frame.
- Config changes during BUSY have no effect on the current frame.
- Boundaries:
  - PRESCALE=0 behaves as PRESCALE=1.
  - PRESCALE at its maximum value does not wrap the counter.
  - The data index must not overflow when DATA_WIDTH=9.

Decomposition:
- Package uart_tx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - START_BIT=0 and STOP_BIT=1 constants;
  - the PRESCALE floor-of-1 helper function.
- Sub-module uart_baud_cnt: a prescale counter with load/enable that emits a bit_end strobe. The FSM, shift register and parity logic stay in the top.

Test Plan:
- Basic parity frame: DATA_WIDTH=8, PRESCALE=4, PAR_EN=1, PAR_TYP=0, STOP2=0, P_DATA=0xA5, one-cycle DATA_VALID.
  - TX_OUT sequence per 4 clocks: 0,1,0,1,0,0,1,0,1,0(parity),1.
  - BUSY high for 44 clocks; TX_DONE pulses once.
- Odd parity with two stop bits: PAR_TYP=1, STOP2=1, P_DATA=0x00, PRESCALE=2.
  - Parity bit=1; stop held 4 clocks; frame is 24 clocks.
- No parity and prescale floor: PAR_EN=0, PRESCALE=0, P_DATA=0xFF.
  - Each bit lasts 1 clock; 10-clock frame.
  - DATA_VALID held high gives a new START exactly 1 idle clock after TX_DONE.
- Mid-frame input changes: change P_DATA, PRESCALE and PAR_EN while BUSY.
  - The frame in flight is unchanged.
  - DATA_VALID pulses during BUSY are dropped, with no second frame.
- Reset mid-frame: assert RST=0 during the DATA bits.
  - TX_OUT=1, BUSY=0 asynchronously.
  - After release the line stays idle until the next DATA_VALID.
- 9-bit mode: DATA_WIDTH=9, P_DATA=0x1FF, PAR_EN=1, even parity.
  - 9 ones are sent, then parity bit 1, then stop.
